dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port data RAM behind the MEM stage. Shares the RAM between the pipeline's MEM-stage access (CPU port) and a secondary block-transfer/I/O DMA requester. The CPU has default priority with a same-cycle path. The DMA gets idle cycles, or a forced slot after a bounded wait; in that forced slot the pipeline is stalled for one cycle.

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: the MEM-stage CPU port has priority, and the DMA gets idle cycles or a forced slot after STARVE_LIMIT blocked cycles.
// Optional statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stall_count,
    output logic [15:0]   dma_count
`endif
);

    localparam int CW = 4;

    logic [CW-1:0] wait_cnt_reg;
    logic [CW-1:0] wait_cnt_next;
    logic          dma_ack_reg;
    logic [DW-1:0] dma_rdata_reg;
    logic          starve;
    logic          dma_slot;

    assign starve   = (wait_cnt_reg == CW'(STARVE_LIMIT));
    // The ack cycle is never a DMA slot, so the requester can safely swap fields.
    assign dma_slot = dma_req & ~dma_ack_reg & (~cpu_req | starve);

    assign cpu_rdata = mem_rdata;
    assign dma_ack   = dma_ack_reg;
    assign dma_rdata = dma_rdata_reg;

    always_comb begin
        if (dma_slot) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
            cpu_stall = cpu_req;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_req & cpu_we;
            cpu_stall = 1'b0;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt_reg;
        if (dma_slot || !dma_req) begin
            wait_cnt_next = '0;
        end else if (cpu_req && !dma_ack_reg && !starve) begin
            wait_cnt_next = wait_cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_reg  <= '0;
            dma_ack_reg   <= 1'b0;
            dma_rdata_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            dma_ack_reg  <= dma_slot;
            if (dma_slot && !dma_we) begin
                dma_rdata_reg <= mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_count_reg;
    logic [15:0] dma_count_reg;

    // Saturating counters; a DMA is counted on the edge that raises its ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
            dma_count_reg   <= '0;
        end else begin
            if (cpu_stall && stall_count_reg != 16'hFFFF) begin
                stall_count_reg <= stall_count_reg + 16'd1;
            end
            if (dma_slot && dma_count_reg != 16'hFFFF) begin
                dma_count_reg <= dma_count_reg + 16'd1;
            end
        end
    end

    assign stall_count = stall_count_reg;
    assign dma_count   = dma_count_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model with a shadow RAM, directed scenarios, then randomized traffic.
module tb_dmem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_stall, dma_ack, mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   stall_count, dma_count;
`endif

    always #5 clock = ~clock;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stall_count(stall_count), .dma_count(dma_count)
`endif
    );

    // RAM clocked on the falling edge; the preload port is used only while the arbiter is idle in reset.
    logic [DW-1:0] ram [64];
    logic          pre_en = 1'b0;
    logic [5:0]    pre_idx = '0;
    logic [DW-1:0] pre_data = '0;
    always @(negedge clock) begin
        if (pre_en) ram[pre_idx] <= pre_data;
        else if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr[7:2]];

    // Transaction-level model state.
    logic [DW-1:0] ref_mem [64];
    bit            m_ack, m_stall, m_grant;
    int            m_blocked;
    logic [DW-1:0] m_rdata;
    int            n_checks = 0;
    int            n_fail = 0;
    logic          obs_stall, obs_ack, obs_we;
    logic [DW-1:0] obs_rdata, obs_wdata;
    logic [AW-1:0] obs_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_cycle();
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ewe;
        bit            eligible;
        eligible = dma_req && !m_ack;
        m_grant  = eligible && (!cpu_req || m_blocked >= LIM);
        if (m_grant) begin
            ea = dma_addr; ed = dma_wdata; ewe = dma_we;
        end else begin
            ea = cpu_addr; ed = cpu_wdata; ewe = cpu_req && cpu_we;
        end
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("cpu_stall", 32'(cpu_stall), 32'(m_grant && cpu_req));
        chk("dma_ack", 32'(dma_ack), 32'(m_ack));
        chk("dma_rdata", dma_rdata, m_rdata);
        chk("cpu_rdata", cpu_rdata, ref_mem[ea[7:2]]);
        obs_stall = cpu_stall; obs_ack = dma_ack; obs_we = mem_we;
        obs_rdata = dma_rdata; obs_wdata = mem_wdata; obs_addr = mem_addr;
    endtask

    task automatic model_update();
        if (m_grant) begin
            if (!dma_we) m_rdata = ref_mem[dma_addr[7:2]];
            else ref_mem[dma_addr[7:2]] = dma_wdata;
            $display("dma %s addr=%h data=%h", dma_we ? "write" : "read ", dma_addr,
                     dma_we ? dma_wdata : m_rdata);
            m_ack     = 1'b1;
            m_blocked = 0;
        end else begin
            if (cpu_req && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
            if (!dma_req) m_blocked = 0;
            else if (!m_ack && cpu_req && m_blocked < LIM) m_blocked++;
            m_ack = 1'b0;
        end
        m_stall = m_grant && cpu_req;
    endtask

    task automatic run_cycle();
        #2;
        check_cycle();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dma(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
    endtask

    task automatic model_reset();
        m_ack = 1'b0; m_blocked = 0; m_rdata = '0; m_stall = 1'b0;
    endtask

    logic [6:0] stall_seen, ack_seen;
    logic [AW-1:0] cyc6_addr;
    logic          cyc6_we;
    logic [DW-1:0] b2b_rdata;
    bit            dpend;

    initial begin
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0);
        model_reset();
        pre_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clock); #1;
            pre_idx  = 6'(i);
            pre_data = (i == 4) ? 32'hDEADBEEF : (i == 5) ? 32'hCAFEF00D : $urandom;
            ref_mem[i] = pre_data;
        end
        @(posedge clock); #1;
        pre_en = 1'b0;
        chk("reset_dma_ack", 32'(dma_ack), 32'd0);
        chk("reset_dma_rdata", dma_rdata, 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;

        // Reset asserted mid-cycle while a DMA request is up.
        set_dma(1, 0, 32'h10, '0);
        run_cycle();
        chk("pre_reset_slot_stall", 32'(obs_stall), 32'd0);
        #2;
        check_cycle();
        chk("pre_reset_ack", 32'(obs_ack), 32'd1);
        model_update();
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_ack", 32'(dma_ack), 32'd0);
        chk("async_reset_rdata", dma_rdata, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();

        // DMA read with the CPU idle.
        run_cycle();
        chk("post_reset_no_ack", 32'(obs_ack), 32'd0);
        chk("read_slot_stall", 32'(obs_stall), 32'd0);
        set_dma(0, 0, 32'h10, '0);
        run_cycle();
        chk("read_ack", 32'(obs_ack), 32'd1);
        chk("read_data", obs_rdata, 32'hDEADBEEF);
        chk("read_ack_stall", 32'(obs_stall), 32'd0);

        // Starvation under a continuous CPU store.
        run_cycle();
        set_cpu(1, 1, 32'h84, 32'h55AA55AA);
        set_dma(1, 1, 32'h20, 32'h12345678);
        stall_seen = '0; ack_seen = '0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) dma_req = 1'b0;
            run_cycle();
            stall_seen[k] = obs_stall;
            ack_seen[k]   = obs_ack;
            if (k == 6) begin
                cyc6_addr = obs_addr;
                cyc6_we   = obs_we;
            end
        end
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("starve_stall_c%0d", k), 32'(stall_seen[k]), 32'(k == 5));
            chk($sformatf("starve_ack_c%0d", k), 32'(ack_seen[k]), 32'(k == 6));
        end
        chk("starve_cpu_addr_c6", cyc6_addr, 32'h84);
        chk("starve_cpu_we_c6", 32'(cyc6_we), 32'd1);
        set_cpu(0, 0, '0, '0);
        run_cycle();
        chk("starve_ram_dma", ram[8], 32'h12345678);
        chk("starve_ram_cpu", ram[33], 32'h55AA55AA);
`ifdef DMEM_ARB_STATS_EN
        chk("stats_stall_count", 32'(stall_count), 32'd1);
        chk("stats_dma_count", 32'(dma_count), 32'd2);
`endif

        // Same-cycle writes to one address: CPU first, then DMA.
        set_cpu(1, 1, 32'h40, 32'hAAAA0000);
        set_dma(1, 1, 32'h40, 32'hBBBB0000);
        run_cycle();
        chk("same_c1_stall", 32'(obs_stall), 32'd0);
        chk("same_c1_wdata", obs_wdata, 32'hAAAA0000);
        set_cpu(0, 0, '0, '0);
        run_cycle();
        chk("same_c2_wdata", obs_wdata, 32'hBBBB0000);
        chk("same_c2_we", 32'(obs_we), 32'd1);
        set_dma(0, 0, '0, '0);
        run_cycle();
        chk("same_c3_ack", 32'(obs_ack), 32'd1);
        chk("same_ram", ram[16], 32'hBBBB0000);

        // Back-to-back DMA reads with the request held through the ack.
        set_dma(1, 0, 32'h10, '0);
        ack_seen = '0;
        b2b_rdata = '0;
        for (int k = 0; k <= 4; k++) begin
            if (k == 1) dma_addr = 32'h14;
            if (k == 3) dma_req = 1'b0;
            run_cycle();
            ack_seen[k] = obs_ack;
            if (k == 3) b2b_rdata = obs_rdata;
        end
        for (int k = 0; k <= 4; k++)
            chk($sformatf("b2b_ack_c%0d", k), 32'(ack_seen[k]), 32'(k == 1 || k == 3));
        chk("b2b_rdata", b2b_rdata, 32'hCAFEF00D);

        // Randomized traffic; a stalled CPU re-presents its request unchanged.
        dpend = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (m_ack) dpend = 1'b0;
            if (!dpend && $urandom_range(0, 2) == 0) begin
                dpend = 1'b1;
                set_dma(1, 1'($urandom), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            end
            dma_req = dpend;
            if (!m_stall)
                set_cpu($urandom_range(0, 9) < 7, 1'($urandom),
                        {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
            run_cycle();
        end
        set_cpu(0, 0, '0, '0);
        set_dma(0, 0, '0, '0);
        run_cycle();
        for (int i = 0; i < 64; i++) chk($sformatf("ram_final_%0d", i), ram[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
